// File: rtl/fft_frame_reader_if.sv
// Stream bundle between the FFT output, the frame reader and its downstream consumer.
// The master side is the frame reader; the slave side is the FFT/consumer environment.
interface fft_frame_reader_if #(
    parameter int unsigned LGWIDTH = 11,
    parameter int unsigned OWIDTH  = 21
);
    logic                i_ce;
    logic [2*OWIDTH-1:0] i_result;
    logic                i_sync;
    logic                o_valid;
    logic                i_ready;
    logic [2*OWIDTH-1:0] o_data;
    logic [LGWIDTH-1:0]  o_bin;
    logic                o_last;
    logic                o_overflow;
    logic                o_syncerr;

    modport master (
        input  i_ce, i_result, i_sync, i_ready,
        output o_valid, o_data, o_bin, o_last, o_overflow, o_syncerr
    );

    modport slave (
        output i_ce, i_result, i_sync, i_ready,
        input  o_valid, o_data, o_bin, o_last, o_overflow, o_syncerr
    );
endinterface

// File: rtl/fft_frame_reader.sv
// Captures natural-order FFT frames into a two-bank buffer and replays each frame over a
// valid/ready stream tagged with its bin index, flagging overruns and misplaced syncs.
module fft_frame_reader #(
    parameter int unsigned LGWIDTH = 11,
    parameter int unsigned OWIDTH  = 21
) (
    input logic                 i_clk,
    input logic                 i_areset_n,
    fft_frame_reader_if.master  bus
);
    localparam int unsigned N  = 1 << LGWIDTH;
    localparam int unsigned DW = 2 * OWIDTH;
    localparam logic [LGWIDTH-1:0] LastIdx = {LGWIDTH{1'b1}};

    typedef enum logic [1:0] {WHunt, WFill, WWait, WDrop} w_state_e;
    typedef enum logic {RIdle, RSend} r_state_e;

    logic [DW-1:0] mem [2*N];
    logic [DW-1:0] rdata_q;

    w_state_e           w_state_q, w_state_d;
    r_state_e           r_state_q, r_state_d;
    logic [LGWIDTH-1:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d, rbin_q, rbin_d;
    logic               wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [1:0]         full_q, full_d;
    logic               more_q, more_d, rv_q, rv_d;
    logic               o_valid_q, o_valid_d, o_last_q, o_last_d;
    logic [DW-1:0]      o_data_q, o_data_d;
    logic [LGWIDTH-1:0] o_bin_q, o_bin_d;
    logic               overflow_q, overflow_d, syncerr_q, syncerr_d;

    logic               wr_en, start, set_full, clr_full, rd_issue;
    logic [LGWIDTH:0]   wr_addr;
    logic               fire, out_load, slot_free;

    // Write side: all progress is gated by i_ce.
    always_comb begin
        w_state_d  = w_state_q;
        wr_idx_d   = wr_idx_q;
        wr_bank_d  = wr_bank_q;
        wr_en      = 1'b0;
        start      = 1'b0;
        set_full   = 1'b0;
        overflow_d = 1'b0;
        syncerr_d  = 1'b0;
        if (bus.i_ce) begin
            unique case (w_state_q)
                WHunt, WWait: begin
                    if (bus.i_sync) begin
                        start = 1'b1;
                    end else if (w_state_q == WWait) begin
                        syncerr_d = 1'b1;
                        w_state_d = WHunt;
                    end
                end
                WFill: begin
                    if (bus.i_sync) begin
                        // Partial frame is abandoned; the bank was never marked full.
                        syncerr_d = 1'b1;
                        start     = 1'b1;
                    end else begin
                        wr_en    = 1'b1;
                        wr_idx_d = wr_idx_q + LGWIDTH'(1);
                        if (wr_idx_q == LastIdx) begin
                            set_full  = 1'b1;
                            wr_bank_d = ~wr_bank_q;
                            w_state_d = WWait;
                        end
                    end
                end
                WDrop: begin
                    if (bus.i_sync) begin
                        start = 1'b1;
                    end else begin
                        wr_idx_d = wr_idx_q + LGWIDTH'(1);
                        if (wr_idx_q == LastIdx) begin
                            w_state_d = WWait;
                        end
                    end
                end
                default: w_state_d = WHunt;
            endcase
        end
        if (start) begin
            wr_idx_d = LGWIDTH'(1);
            // A bank freed by the reader on this same edge still counts as full.
            if (full_q[wr_bank_q]) begin
                overflow_d = 1'b1;
                w_state_d  = WDrop;
            end else begin
                wr_en     = 1'b1;
                w_state_d = WFill;
            end
        end
        wr_addr = {wr_bank_q, (start ? {LGWIDTH{1'b0}} : wr_idx_q)};
    end

    // Read side: memory output register acts as the one-entry prefetch/skid stage.
    always_comb begin
        fire      = o_valid_q & bus.i_ready;
        out_load  = ~o_valid_q | fire;
        slot_free = ~rv_q | out_load;
        r_state_d = r_state_q;
        rd_idx_d  = rd_idx_q;
        rd_bank_d = rd_bank_q;
        more_d    = more_q;
        rd_issue  = 1'b0;
        clr_full  = 1'b0;
        unique case (r_state_q)
            RIdle: begin
                if (full_q[rd_bank_q]) begin
                    rd_issue  = 1'b1;
                    rd_idx_d  = rd_idx_q + LGWIDTH'(1);
                    more_d    = 1'b1;
                    r_state_d = RSend;
                end
            end
            RSend: begin
                if (more_q && slot_free) begin
                    rd_issue = 1'b1;
                    rd_idx_d = rd_idx_q + LGWIDTH'(1);
                    if (rd_idx_q == LastIdx) begin
                        more_d = 1'b0;
                    end
                end
                if (fire && o_last_q) begin
                    clr_full  = 1'b1;
                    rd_bank_d = ~rd_bank_q;
                    r_state_d = RIdle;
                end
            end
            default: r_state_d = RIdle;
        endcase

        rv_d   = rd_issue | (rv_q & ~out_load);
        rbin_d = rd_issue ? rd_idx_q : rbin_q;

        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        o_bin_d   = o_bin_q;
        o_last_d  = o_last_q;
        if (out_load) begin
            o_valid_d = rv_q;
            o_data_d  = rdata_q;
            o_bin_d   = rbin_q;
            o_last_d  = rv_q & (rbin_q == LastIdx);
        end

        full_d = full_q;
        if (clr_full) full_d[rd_bank_q] = 1'b0;
        if (set_full) full_d[wr_bank_q] = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            w_state_q  <= WHunt;
            r_state_q  <= RIdle;
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            rbin_q     <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            full_q     <= '0;
            more_q     <= 1'b0;
            rv_q       <= 1'b0;
            o_valid_q  <= 1'b0;
            o_data_q   <= '0;
            o_bin_q    <= '0;
            o_last_q   <= 1'b0;
            overflow_q <= 1'b0;
            syncerr_q  <= 1'b0;
        end else begin
            w_state_q  <= w_state_d;
            r_state_q  <= r_state_d;
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
            rbin_q     <= rbin_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            full_q     <= full_d;
            more_q     <= more_d;
            rv_q       <= rv_d;
            o_valid_q  <= o_valid_d;
            o_data_q   <= o_data_d;
            o_bin_q    <= o_bin_d;
            o_last_q   <= o_last_d;
            overflow_q <= overflow_d;
            syncerr_q  <= syncerr_d;
        end
    end

    // Buffer RAM: contents are intentionally not reset.
    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wr_addr] <= bus.i_result;
        if (rd_issue) rdata_q <= mem[{rd_bank_q, rd_idx_q}];
    end

    assign bus.o_valid    = o_valid_q;
    assign bus.o_data     = o_data_q;
    assign bus.o_bin      = o_bin_q;
    assign bus.o_last     = o_last_q;
    assign bus.o_overflow = overflow_q;
    assign bus.o_syncerr  = syncerr_q;
endmodule

// File: tb/tb_fft_frame_reader.sv
// Randomized bench for fft_frame_reader: a frame-level model predicts which frames are
// replayed and how many overflow/sync-error pulses appear.
module tb_fft_frame_reader;
    localparam int unsigned LGWIDTH = 11;
    localparam int unsigned OWIDTH  = 21;
    localparam int unsigned N       = 1 << LGWIDTH;
    localparam int unsigned DW      = 2 * OWIDTH;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    fft_frame_reader_if #(.LGWIDTH(LGWIDTH), .OWIDTH(OWIDTH)) bus ();

    fft_frame_reader #(.LGWIDTH(LGWIDTH), .OWIDTH(OWIDTH)) dut (
        .i_clk      (clk),
        .i_areset_n (rst_n),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0]      data;
        logic [LGWIDTH-1:0] bin;
    } samp_t;

    int n_cmp = 0;
    int n_err = 0;

    samp_t         exp_q[$];
    logic [DW-1:0] part_q[$];
    bit            in_frame, dropping, need_sync;
    int            drop_cnt, stored, consumed;
    int            exp_ovf, exp_serr, got_ovf, got_serr;
    int            ready_mode;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Frame-level model: a frame is kept only if it starts on a sync while a bank is free
    // and completes N samples without another sync.
    task automatic model_sample(input logic sync, input logic [DW-1:0] data);
        if (sync) begin
            if (in_frame) exp_serr++;
            need_sync = 1'b0;
            part_q.delete();
            if (stored - consumed >= 2) begin
                exp_ovf++;
                dropping = 1'b1;
                in_frame = 1'b0;
                drop_cnt = 1;
            end else begin
                dropping = 1'b0;
                in_frame = 1'b1;
                part_q.push_back(data);
            end
        end else if (in_frame) begin
            part_q.push_back(data);
            if (part_q.size() == N) begin
                foreach (part_q[i]) begin
                    samp_t s;
                    s.data = part_q[i];
                    s.bin  = LGWIDTH'(i);
                    exp_q.push_back(s);
                end
                part_q.delete();
                stored++;
                in_frame  = 1'b0;
                need_sync = 1'b1;
            end
        end else if (dropping) begin
            drop_cnt++;
            if (drop_cnt == N) begin
                dropping  = 1'b0;
                need_sync = 1'b1;
            end
        end else if (need_sync) begin
            exp_serr++;
            need_sync = 1'b0;
        end
    endtask

    task automatic drive(input logic ce, input logic sync, input logic [DW-1:0] data);
        @(posedge clk);
        #1;
        bus.i_ce     = ce;
        bus.i_sync   = sync;
        bus.i_result = data;
        if (ce) model_sample(sync, data);
    endtask

    // n samples, optional sync on the first, gap idle cycles (with junk) after each sample.
    task automatic send_seq(input int n, input bit with_sync, input bit rnd, input int gap);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, with_sync && (i == 0), rnd ? DW'({$urandom, $urandom}) : DW'(i));
            for (int g = 0; g < gap; g++) begin
                drive(1'b0, 1'($urandom_range(0, 1)), DW'({$urandom, $urandom}));
            end
        end
    endtask

    task automatic do_reset();
        bus.i_ce     = 1'b0;
        bus.i_sync   = 1'b0;
        bus.i_result = '0;
        rst_n = 1'b0;
        #1;
        check_eq("rst_out", 64'({bus.o_valid, bus.o_data, bus.o_bin, bus.o_last,
                                 bus.o_overflow, bus.o_syncerr}), 64'(0));
        exp_q.delete();
        part_q.delete();
        in_frame = 0; dropping = 0; need_sync = 0;
        drop_cnt = 0; stored = 0; consumed = 0;
        exp_ovf = 0; exp_serr = 0; got_ovf = 0; got_serr = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || bus.o_valid) && k < 20000) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, 64'(exp_q.size()), 64'(0));
        repeat (4) @(negedge clk);
        check_eq({tag, "_ovf"}, 64'(got_ovf), 64'(exp_ovf));
        check_eq({tag, "_serr"}, 64'(got_serr), 64'(exp_serr));
    endtask

    initial begin
        bus.i_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.i_ready = 1'b0;
                1:       bus.i_ready = 1'b1;
                default: bus.i_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output monitor: scoreboard on each handshake, hold check while stalled.
    initial begin
        logic        held;
        logic [63:0] held_v, cur;
        samp_t       s;
        held = 1'b0;
        held_v = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                cur = 64'({bus.o_data, bus.o_bin, bus.o_last});
                if (held) check_eq("stable", {bus.o_valid, cur[62:0]}, {1'b1, held_v[62:0]});
                held   = bus.o_valid && !bus.i_ready;
                held_v = cur;
                if (bus.o_valid && bus.i_ready) begin
                    check_eq("out_avail", 64'(exp_q.size() != 0), 64'(1));
                    if (exp_q.size() != 0) begin
                        s = exp_q.pop_front();
                        check_eq("sample", cur,
                                 64'({s.data, s.bin, 1'(s.bin == LGWIDTH'(N - 1))}));
                        if (s.bin == LGWIDTH'(N - 1)) consumed++;
                    end
                end
                got_ovf  += int'(bus.o_overflow);
                got_serr += int'(bus.o_syncerr);
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin
        bit found;
        ready_mode = 1;

        // Single frame, data = bin index, exact replay latency.
        do_reset();
        send_seq(N, 1'b1, 1'b0, 0);
        drive(1'b0, 1'b0, '0);
        @(negedge clk); check_eq("lat_t0", 64'(bus.o_valid), 64'(0));
        @(negedge clk); check_eq("lat_t1", 64'(bus.o_valid), 64'(0));
        @(negedge clk); check_eq("lat_t2", 64'(bus.o_valid), 64'(1));
        check_eq("lat_bin", 64'(bus.o_bin), 64'(0));
        drain("t1");

        // Three back-to-back frames against a stalled consumer.
        do_reset();
        ready_mode = 0;
        repeat (3) send_seq(N, 1'b1, 1'b1, 0);
        drive(1'b0, 1'b0, '0);
        repeat (20) @(negedge clk);
        check_eq("t2_pending", 64'(exp_q.size()), 64'(2 * N));
        ready_mode = 1;
        drain("t2");

        // Sync at bin 700: partial frame discarded, restart replayed intact.
        do_reset();
        send_seq(700, 1'b1, 1'b1, 0);
        send_seq(N, 1'b1, 1'b1, 0);
        drive(1'b0, 1'b0, '0);
        drain("t3");

        // 1/3 duty input, random back-pressure, two frames.
        do_reset();
        ready_mode = 2;
        repeat (2) send_seq(N, 1'b1, 1'b1, 2);
        drive(1'b0, 1'b0, '0);
        drain("t4");

        // Reset mid-output, then a clean frame.
        do_reset();
        ready_mode = 1;
        send_seq(N, 1'b1, 1'b1, 0);
        drive(1'b0, 1'b0, '0);
        found = 1'b0;
        for (int k = 0; k < 5000 && !found; k++) begin
            @(negedge clk);
            if (bus.o_valid && bus.o_bin == LGWIDTH'(1000)) found = 1'b1;
        end
        check_eq("t5_reach", 64'(found), 64'(1));
        #2;
        do_reset();
        send_seq(N, 1'b1, 1'b1, 0);
        drive(1'b0, 1'b0, '0);
        drain("t5");

        // Unsynced frame after reset is ignored, then a synced frame is stored.
        do_reset();
        send_seq(N, 1'b0, 1'b1, 0);
        repeat (10) @(negedge clk);
        check_eq("t6_idle", 64'(bus.o_valid), 64'(0));
        send_seq(N, 1'b1, 1'b0, 0);
        drive(1'b0, 1'b0, '0);
        drain("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
